// File: rtl/xgmii_pkg.sv
// Shared constants, state encoding and lane classification for the
// XGMII to GMII transmit serializer.
package xgmii_pkg;

    localparam logic [7:0] XGMII_START   = 8'hFB;
    localparam logic [7:0] XGMII_TERM    = 8'hFD;
    localparam logic [7:0] XGMII_IDLE    = 8'h07;
    localparam logic [7:0] XGMII_ERR     = 8'hFE;
    localparam logic [7:0] GMII_PREAMBLE = 8'h55;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_IFG   = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic is_data;
        logic is_start;
        logic is_term;
        logic is_idle;
        logic is_err;
    } lane_kind_t;

endpackage

// File: rtl/xgmii2gmii_tx_decode.sv
// Classifies one XGMII lane (control bit + byte) into exactly one kind.
// Ports: ctl_i/byte_i lane in, kind_o one-hot classification out.
module xgmii_lane_decode
    import xgmii_pkg::*;
(
    input  logic       ctl_i,
    input  logic [7:0] byte_i,
    output lane_kind_t kind_o
);

    always_comb begin
        kind_o = '0;
        if (!ctl_i) begin
            kind_o.is_data = 1'b1;
        end else begin
            unique case (byte_i)
                XGMII_START: kind_o.is_start = 1'b1;
                XGMII_TERM:  kind_o.is_term  = 1'b1;
                XGMII_IDLE:  kind_o.is_idle  = 1'b1;
                default:     kind_o.is_err   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/xgmii2gmii_tx.sv
// Serializes 72-bit XGMII words from a FIFO onto an 8-bit GMII TX stream.
// Ports: gmii_clk/sys_rst, fifo_dout/fifo_empty/fifo_rd_en (FIFO side),
// gmii_en/gmii_txd (GMII side), frame_count/underrun_count (status).
// Build option GMII_ER_EN adds gmii_er and in-band error signalling.
module xgmii2gmii_tx
    import xgmii_pkg::*;
#(
    parameter int IFG_MIN = 12,
    parameter int CNT_W   = 16
) (
    input  logic             gmii_clk,
    input  logic             sys_rst,
    input  logic [71:0]      fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             gmii_en,
`ifdef GMII_ER_EN
    output logic             gmii_er,
`endif
    output logic [7:0]       gmii_txd,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] underrun_count
);

    localparam logic [7:0] IFG_INIT = 8'(IFG_MIN);
    localparam logic [7:0] IFG_LAST = 8'(IFG_MIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [71:0] WORD_RST = {8'hFF, {8{XGMII_IDLE}}};

    tx_state_e        state_q, state_d;
    logic [71:0]      word_q, word_d;
    logic [2:0]       lane_q, lane_d;
    logic             wv_q, wv_d;
    logic             rd_q, rd_d;
    logic             cap_q;
    logic [7:0]       ifg_q, ifg_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] ucnt_q, ucnt_d;

    logic [7:0]  txc_w;
    logic [63:0] txd_w;
    logic        lane_ctl;
    logic [7:0]  lane_byte;
    lane_kind_t  kind;
    logic [7:0]  ifg_inc;
    logic        advance;
    logic        drop;
    logic        pop_ok;

    assign txc_w     = word_q[71:64];
    assign txd_w     = word_q[63:0];
    assign lane_ctl  = txc_w[lane_q];
    assign lane_byte = txd_w[{lane_q, 3'b000} +: 8];
    assign ifg_inc   = (ifg_q == 8'hFF) ? ifg_q : ifg_q + 8'd1;

    xgmii_lane_decode u_dec (
        .ctl_i  (lane_ctl),
        .byte_i (lane_byte),
        .kind_o (kind)
    );

    // After an underrun or abort the machine lands in IDLE, whose
    // discard-until-/S/-in-lane-0/4 rule is exactly the resync rule,
    // so no separate resync state is kept.
    always_comb begin
        state_d  = state_q;
        ifg_d    = ifg_q;
        fcnt_d   = fcnt_q;
        ucnt_d   = ucnt_q;
        advance  = 1'b0;
        drop     = 1'b0;
        gmii_en  = 1'b0;
        gmii_txd = 8'h00;
`ifdef GMII_ER_EN
        gmii_er  = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                ifg_d = ifg_inc;
                if (wv_q) begin
                    advance = 1'b1;
                    if (kind.is_start &&
                        (lane_q == 3'd0 || lane_q == 3'd4)) begin
                        gmii_en  = 1'b1;
                        gmii_txd = GMII_PREAMBLE;
                        state_d  = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                if (!wv_q) begin
                    // Pipeline ran dry at a word boundary.
                    ucnt_d  = ucnt_q + CNT_ONE;
                    ifg_d   = 8'd0;
                    state_d = ST_IFG;
`ifdef GMII_ER_EN
                    gmii_en  = 1'b1;
                    gmii_er  = 1'b1;
                    gmii_txd = XGMII_ERR;
`endif
                end else if (kind.is_data) begin
                    gmii_en  = 1'b1;
                    gmii_txd = lane_byte;
                    advance  = 1'b1;
                end else if (kind.is_term) begin
                    fcnt_d  = fcnt_q + CNT_ONE;
                    drop    = 1'b1;
                    ifg_d   = 8'd0;
                    state_d = ST_IFG;
                end else if (kind.is_start || kind.is_idle ||
                             kind.is_err) begin
`ifdef GMII_ER_EN
                    gmii_en  = 1'b1;
                    gmii_er  = 1'b1;
                    gmii_txd = XGMII_ERR;
                    advance  = 1'b1;
`else
                    ucnt_d  = ucnt_q + CNT_ONE;
                    drop    = 1'b1;
                    ifg_d   = 8'd0;
                    state_d = ST_IFG;
`endif
                end
            end
            ST_IFG: begin
                // Lanes are frozen here, so an early /S/ waits in word_q.
                ifg_d = ifg_inc;
                if (ifg_q >= IFG_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A freshly arriving word wins over retiring the old one.
        word_d = word_q;
        lane_d = lane_q;
        wv_d   = wv_q;
        if (cap_q) begin
            word_d = fifo_dout;
            lane_d = 3'd0;
            wv_d   = 1'b1;
        end else if (drop) begin
            wv_d = 1'b0;
        end else if (advance) begin
            lane_d = lane_q + 3'd1;
            wv_d   = (lane_q != 3'd7);
        end

        // Popping at lane 5 puts rd_en high in lane 6 and the new word
        // into word_q exactly as lane 7 retires.
        pop_ok = !fifo_empty && !rd_q && !cap_q &&
                 ((state_q == ST_IDLE && ifg_q >= IFG_INIT) ||
                  state_q == ST_FRAME);
        rd_d = pop_ok &&
               ((!wv_q && state_q == ST_IDLE) ||
                (wv_q && advance && lane_q == 3'd5));
    end

    always_ff @(posedge gmii_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            word_q  <= WORD_RST;
            lane_q  <= 3'd0;
            wv_q    <= 1'b0;
            rd_q    <= 1'b0;
            cap_q   <= 1'b0;
            ifg_q   <= IFG_INIT;
            fcnt_q  <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            wv_q    <= wv_d;
            rd_q    <= rd_d;
            cap_q   <= rd_q;
            ifg_q   <= ifg_d;
            fcnt_q  <= fcnt_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign fifo_rd_en     = rd_q;
    assign frame_count    = fcnt_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_xgmii2gmii_tx.sv
// Scoreboard bench for xgmii2gmii_tx: a FIFO model feeds words, a
// monitor checks every GMII byte, frame length and inter-frame gap.
module tb_xgmii2gmii_tx;
    import xgmii_pkg::*;

    localparam int IFG_MIN = 12;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic       c;
        logic [7:0] d;
    } lane_t;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
    } exp_t;

    logic             gmii_clk = 1'b0;
    logic             sys_rst;
    logic [71:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             gmii_en;
    logic [7:0]       gmii_txd;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] underrun_count;
`ifdef GMII_ER_EN
    logic             gmii_er;
`endif

    int checks = 0;
    int errors = 0;
    int mon_bytes = 0;
    int rst_events = 0;

    lane_t       lanes[$];
    logic [71:0] fifo_q[$];
    exp_t        exp_q[$];
    int          len_q[$];

    xgmii2gmii_tx #(.IFG_MIN(IFG_MIN), .CNT_W(CNT_W)) dut (
        .gmii_clk       (gmii_clk),
        .sys_rst        (sys_rst),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .gmii_en        (gmii_en),
`ifdef GMII_ER_EN
        .gmii_er        (gmii_er),
`endif
        .gmii_txd       (gmii_txd),
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
    );

    always #4 gmii_clk = ~gmii_clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] dbyte(input int seed, input int i);
        return 8'(seed + i);
    endfunction

    task automatic add_lane(input logic c, input logic [7:0] d);
        lanes.push_back('{c: c, d: d});
    endtask

    task automatic flush_lanes();
        logic [71:0] w;
        lane_t l;
        while (lanes.size() > 0) begin
            w = {8'hFF, {8{8'h07}}};
            for (int i = 0; i < 8; i++) begin
                if (lanes.size() > 0) begin
                    l = lanes.pop_front();
                    w[64 + i] = l.c;
                    w[8 * i +: 8] = l.d;
                end
            end
            fifo_q.push_back(w);
        end
    endtask

    // err_k < 0 means no error character in the payload.
    task automatic send_frame(input int lead, input int ndata,
                              input int seed, input bit term,
                              input int err_k);
        for (int i = 0; i < lead; i++) add_lane(1'b1, 8'h07);
        add_lane(1'b1, 8'hFB);
        for (int i = 0; i < 6; i++) add_lane(1'b0, 8'h55);
        add_lane(1'b0, 8'hD5);
        for (int i = 0; i < ndata; i++) begin
            if (i == err_k) add_lane(1'b1, 8'hFE);
            else add_lane(1'b0, dbyte(seed, i));
        end
        if (term) add_lane(1'b1, 8'hFD);
        flush_lanes();
    endtask

    task automatic exp_byte(input logic [7:0] dv, input logic erv);
        exp_q.push_back('{d: dv, er: erv});
    endtask

    task automatic exp_pre();
        for (int i = 0; i < 7; i++) exp_byte(8'h55, 1'b0);
        exp_byte(8'hD5, 1'b0);
    endtask

    task automatic exp_good(input int ndata, input int seed);
        exp_pre();
        for (int i = 0; i < ndata; i++) exp_byte(dbyte(seed, i), 1'b0);
        len_q.push_back(8 + ndata);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 ||
                len_q.size() != 0 || gmii_en) && n < 4000) begin
            @(posedge gmii_clk);
            #1;
            n++;
        end
        check({name, "_drain"}, 32'(n < 4000), 32'd1);
        repeat (40) @(posedge gmii_clk);
        #1;
    endtask

    task automatic counters(input string name, input int fc,
                            input int uc);
        check({name, "_frames"}, 32'(frame_count), 32'(fc));
        check({name, "_underruns"}, 32'(underrun_count), 32'(uc));
    endtask

    // FIFO model: dout updates mid-cycle of the pop, valid next cycle.
    initial begin
        fifo_dout  = '0;
        fifo_empty = 1'b1;
        forever begin
            @(negedge gmii_clk);
            if (fifo_rd_en) begin
                if (fifo_q.size() == 0) begin
                    check("pop_when_empty", 32'd1, 32'd0);
                end else begin
                    fifo_dout = fifo_q.pop_front();
                end
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor
    int   m_run = 0;
    int   m_low = 0;
    int   m_seen_rst = 0;
    bit   m_prev = 1'b0;
    bit   m_disc = 1'b0;
    exp_t m_e;
    int   m_len;

    initial begin
        forever begin
            @(negedge gmii_clk);
            if (rst_events != m_seen_rst) begin
                m_seen_rst = rst_events;
                m_disc = 1'b1;
            end
            if (m_disc) begin
                if (!gmii_en) begin
                    m_disc = 1'b0;
                    m_run  = 0;
                    m_low  = IFG_MIN;
                    m_prev = 1'b0;
                end
            end else if (gmii_en) begin
                if (m_run == 0 && m_prev) begin
                    check("ifg_gap_ok", 32'(m_low >= IFG_MIN), 32'd1);
                end
                m_run++;
                mon_bytes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, gmii_txd}, 32'hDEAD);
                end else begin
                    m_e = exp_q.pop_front();
                    check("txd", {24'd0, gmii_txd}, {24'd0, m_e.d});
`ifdef GMII_ER_EN
                    check("er", {31'd0, gmii_er}, {31'd0, m_e.er});
`endif
                end
            end else begin
                if (m_run != 0) begin
                    if (len_q.size() == 0) begin
                        check("unexpected_frame", 32'(m_run), 32'd0);
                    end else begin
                        m_len = len_q.pop_front();
                        check("frame_len", 32'(m_run), 32'(m_len));
                    end
                    m_run  = 0;
                    m_low  = 0;
                    m_prev = 1'b1;
                end
                m_low++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        sys_rst = 1'b1;
        repeat (3) @(posedge gmii_clk);
        @(negedge gmii_clk);
        check("rst_en", {31'd0, gmii_en}, 32'd0);
        check("rst_txd", {24'd0, gmii_txd}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
`ifdef GMII_ER_EN
        check("rst_er", {31'd0, gmii_er}, 32'd0);
`endif
        counters("rst", 0, 0);
        @(posedge gmii_clk);
        #1;
        sys_rst = 1'b0;

        // A: /S/ lane 0, 67 data bytes, /T/ in lane 3 of last word
        exp_good(67, 8'h10);
        send_frame(0, 67, 8'h10, 1'b1, -1);
        wait_quiet("A");
        counters("A", 1, 0);

        // B: /S/ in lane 4
        exp_good(20, 8'h80);
        send_frame(4, 20, 8'h80, 1'b1, -1);
        wait_quiet("B");
        counters("B", 2, 0);

        // C: /S/ in lane 2 must be ignored entirely
        send_frame(2, 10, 8'hC0, 1'b1, -1);
        wait_quiet("C");
        counters("C", 2, 0);

        // D/E: back to back, FIFO preloaded
        exp_good(30, 8'h20);
        exp_good(40, 8'h40);
        send_frame(0, 30, 8'h20, 1'b1, -1);
        send_frame(0, 40, 8'h40, 1'b1, -1);
        wait_quiet("DE");
        counters("DE", 4, 0);

        // U: FIFO runs dry after word 3 (preamble + 24 bytes)
        exp_pre();
        for (int i = 0; i < 24; i++) exp_byte(dbyte(8'h60, i), 1'b0);
`ifdef GMII_ER_EN
        exp_byte(8'hFE, 1'b1);
        len_q.push_back(33);
`else
        len_q.push_back(32);
`endif
        send_frame(0, 24, 8'h60, 1'b0, -1);
        wait_quiet("U");
        counters("U", 4, 1);
        // stale tail of U then a clean frame F
        for (int i = 0; i < 3; i++) add_lane(1'b0, 8'hAA);
        add_lane(1'b1, 8'hFD);
        flush_lanes();
        exp_good(16, 8'hA0);
        send_frame(0, 16, 8'hA0, 1'b1, -1);
        wait_quiet("F");
        counters("F", 5, 1);

        // G: error char at payload byte 13 = lane 5 of word 2
        exp_pre();
`ifdef GMII_ER_EN
        for (int i = 0; i < 30; i++) begin
            if (i == 13) exp_byte(8'hFE, 1'b1);
            else exp_byte(dbyte(8'h30, i), 1'b0);
        end
        len_q.push_back(38);
`else
        for (int i = 0; i < 13; i++) exp_byte(dbyte(8'h30, i), 1'b0);
        len_q.push_back(21);
`endif
        send_frame(0, 30, 8'h30, 1'b1, 13);
        wait_quiet("G");
`ifdef GMII_ER_EN
        counters("G", 6, 1);
`else
        counters("G", 5, 2);
`endif

        // H: reset after 10 bytes of a 40-byte frame
        base = mon_bytes;
        exp_good(40, 8'h50);
        send_frame(0, 40, 8'h50, 1'b1, -1);
        n = 0;
        while (mon_bytes < base + 10 && n < 2000) begin
            @(posedge gmii_clk);
            #1;
            n++;
        end
        check("H_started", 32'(n < 2000), 32'd1);
        rst_events++;
        sys_rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        @(posedge gmii_clk);
        @(negedge gmii_clk);
        check("H_rst_en", {31'd0, gmii_en}, 32'd0);
        counters("H_rst", 0, 0);
        @(posedge gmii_clk);
        #1;
        sys_rst = 1'b0;
        wait_quiet("H_flush");
        counters("H_flush", 0, 0);

        // I: frame after reset goes through intact
        exp_good(12, 8'hE0);
        send_frame(0, 12, 8'hE0, 1'b1, -1);
        wait_quiet("I");
        counters("I", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
